// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode map, instruction classes and IR field positions,
// used by the fetch, decode and execute stages.
package decode_stage_pkg;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_ADDI = 8'h10;
  localparam logic [7:0] OP_SUBI = 8'h11;
  localparam logic [7:0] OP_LDW  = 8'h20;
  localparam logic [7:0] OP_STW  = 8'h21;
  localparam logic [7:0] OP_BR   = 8'h30;
  localparam logic [7:0] OP_JMP  = 8'h31;
  localparam logic [7:0] OP_HALT = 8'hF0;
  localparam logic [7:0] OP_NOP  = 8'hFF;

  localparam int IR_OP_MSB   = 31;
  localparam int IR_OP_LSB   = 24;
  localparam int IR_DEST_MSB = 23;
  localparam int IR_DEST_LSB = 20;
  localparam int IR_SRC1_MSB = 19;
  localparam int IR_SRC1_LSB = 16;
  localparam int IR_SRC2_MSB = 15;
  localparam int IR_SRC2_LSB = 12;
  localparam int IR_IMM_MSB  = 15;
  localparam int IR_IMM_LSB  = 0;

  typedef enum logic [2:0] {
    CLS_ALU_RR,
    CLS_ALU_RI,
    CLS_LDW,
    CLS_STW,
    CLS_BR,
    CLS_JMP,
    CLS_HALT,
    CLS_NOP
  } op_class_e;

  // Unassigned opcodes decode as NOP so they never issue.
  function automatic op_class_e op_class(input logic [7:0] op);
    op_class_e c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: c = CLS_ALU_RR;
      OP_ADDI, OP_SUBI:              c = CLS_ALU_RI;
      OP_LDW:                        c = CLS_LDW;
      OP_STW:                        c = CLS_STW;
      OP_BR:                         c = CLS_BR;
      OP_JMP:                        c = CLS_JMP;
      OP_HALT:                       c = CLS_HALT;
      default:                       c = CLS_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile_sb.sv
// GPR file (2 read, 1 write) with per-register busy bits; a same-cycle writeback
// is forwarded to the read ports and masks the busy bit of that register.
module decode_regfile_sb #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_REGS)-1:0] rd1_idx,
  input  logic [$clog2(NUM_REGS)-1:0] rd2_idx,
  output logic [DATA_WIDTH-1:0]       rd1_data,
  output logic [DATA_WIDTH-1:0]       rd2_data,
  output logic                        rd1_busy,
  output logic                        rd2_busy,
  input  logic                        wb_en,
  input  logic [$clog2(NUM_REGS)-1:0] wb_idx,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  input  logic                        set_en,
  input  logic [$clog2(NUM_REGS)-1:0] set_idx
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] gpr_q, gpr_d;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;
  logic                                rd1_byp, rd2_byp;

  assign rd1_byp  = wb_en && (wb_idx == rd1_idx);
  assign rd2_byp  = wb_en && (wb_idx == rd2_idx);
  assign rd1_data = rd1_byp ? wb_data : gpr_q[rd1_idx];
  assign rd2_data = rd2_byp ? wb_data : gpr_q[rd2_idx];
  assign rd1_busy = busy_q[rd1_idx] && !rd1_byp;
  assign rd2_busy = busy_q[rd2_idx] && !rd2_byp;

  // Issue set is applied after the writeback clear so it wins on the same register.
  always_comb begin
    gpr_d  = gpr_q;
    busy_d = busy_q;
    if (wb_en) begin
      gpr_d[wb_idx]  = wb_data;
      busy_d[wb_idx] = 1'b0;
    end
    if (set_en) begin
      busy_d[set_idx] = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q  <= '0;
      busy_q <= '0;
    end else begin
      gpr_q  <= gpr_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: FE/DE latch to DE/EX latch with scoreboard RAW interlock and branch hold.
// State advances on the falling edge of I_CLOCK; I_LOCK low is an asynchronous reset.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16,
  parameter int IR_WIDTH   = 32
) (
  input  logic                        I_CLOCK,
  input  logic                        I_LOCK,
  input  logic [PC_WIDTH-1:0]         I_PC,
  input  logic [IR_WIDTH-1:0]         I_IR,
  input  logic                        I_FetchStall,
  input  logic                        I_WriteBackEnable,
  input  logic [$clog2(NUM_REGS)-1:0] I_WriteBackRegIdx,
  input  logic [DATA_WIDTH-1:0]       I_WriteBackData,
  input  logic                        I_BranchAddrSelect,
  output logic                        O_LOCK,
  output logic [PC_WIDTH-1:0]         O_PC,
  output logic [7:0]                  O_Opcode,
  output logic [$clog2(NUM_REGS)-1:0] O_DestRegIdx,
  output logic [DATA_WIDTH-1:0]       O_Src1Value,
  output logic [DATA_WIDTH-1:0]       O_Src2Value,
  output logic                        O_DepStall,
  output logic                        O_DepStallSignal,
  output logic                        O_BranchStallSignal
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [7:0]            opcode;
  logic [IDX_W-1:0]      dest_idx, src1_idx, src2_idx;
  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] imm_ext, rd1_data, rd2_data, src2_val;
  logic                  rd1_busy, rd2_busy;
  op_class_e             cls;
  logic                  writes_dest, reads_src1, reads_src2, is_branch;
  logic                  valid, hazard, issue;

  logic                  lock_q, lock_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [IDX_W-1:0]      dest_q, dest_d;
  logic [DATA_WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
  logic                  dep_stall_q, dep_stall_d;
  logic                  branch_pending_q, branch_pending_d;

  assign opcode   = I_IR[IR_OP_MSB:IR_OP_LSB];
  assign dest_idx = I_IR[IR_DEST_MSB:IR_DEST_LSB];
  assign src1_idx = I_IR[IR_SRC1_MSB:IR_SRC1_LSB];
  assign src2_idx = I_IR[IR_SRC2_MSB:IR_SRC2_LSB];
  assign imm      = I_IR[IR_IMM_MSB:IR_IMM_LSB];
  assign imm_ext  = DATA_WIDTH'($signed(imm));
  assign cls      = op_class(opcode);

  always_comb begin
    writes_dest = 1'b0;
    reads_src1  = 1'b0;
    reads_src2  = 1'b0;
    is_branch   = 1'b0;
    case (cls)
      CLS_ALU_RR: begin writes_dest = 1'b1; reads_src1 = 1'b1; reads_src2 = 1'b1; end
      CLS_ALU_RI: begin writes_dest = 1'b1; reads_src1 = 1'b1; end
      CLS_LDW:    begin writes_dest = 1'b1; reads_src1 = 1'b1; end
      CLS_STW:    begin reads_src1 = 1'b1; reads_src2 = 1'b1; end
      CLS_BR:     begin reads_src1 = 1'b1; is_branch = 1'b1; end
      CLS_JMP:    is_branch = 1'b1;
      default:    ;
    endcase
  end

  // Gating with I_LOCK lets the stall outputs fall as soon as reset asserts.
  assign valid    = I_LOCK && !I_FetchStall && (cls != CLS_NOP);
  assign hazard   = valid && ((reads_src1 && rd1_busy) || (reads_src2 && rd2_busy));
  assign issue    = valid && !hazard && !branch_pending_q;
  assign src2_val = reads_src2 ? rd2_data : imm_ext;

  assign O_DepStallSignal    = hazard && !branch_pending_q;
  assign O_BranchStallSignal = branch_pending_q || (valid && is_branch && !hazard);

  decode_regfile_sb #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile_sb (
    .clk      (I_CLOCK),
    .rst_n    (I_LOCK),
    .rd1_idx  (src1_idx),
    .rd2_idx  (src2_idx),
    .rd1_data (rd1_data),
    .rd2_data (rd2_data),
    .rd1_busy (rd1_busy),
    .rd2_busy (rd2_busy),
    .wb_en    (I_WriteBackEnable),
    .wb_idx   (I_WriteBackRegIdx),
    .wb_data  (I_WriteBackData),
    .set_en   (issue && writes_dest),
    .set_idx  (dest_idx)
  );

  // Non-issue edges present a NOP bubble; the remaining DE/EX fields hold.
  always_comb begin
    lock_d      = I_LOCK;
    pc_d        = pc_q;
    opcode_d    = OP_NOP;
    dest_d      = dest_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    dep_stall_d = 1'b1;
    if (issue) begin
      pc_d        = I_PC;
      opcode_d    = opcode;
      dest_d      = dest_idx;
      src1_d      = rd1_data;
      src2_d      = src2_val;
      dep_stall_d = 1'b0;
    end
    branch_pending_d = branch_pending_q;
    if (issue && is_branch) begin
      branch_pending_d = 1'b1;
    end else if (I_BranchAddrSelect) begin
      branch_pending_d = 1'b0;
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      lock_q           <= 1'b0;
      pc_q             <= '0;
      opcode_q         <= OP_NOP;
      dest_q           <= '0;
      src1_q           <= '0;
      src2_q           <= '0;
      dep_stall_q      <= 1'b1;
      branch_pending_q <= 1'b0;
    end else begin
      lock_q           <= lock_d;
      pc_q             <= pc_d;
      opcode_q         <= opcode_d;
      dest_q           <= dest_d;
      src1_q           <= src1_d;
      src2_q           <= src2_d;
      dep_stall_q      <= dep_stall_d;
      branch_pending_q <= branch_pending_d;
    end
  end

  assign O_LOCK       = lock_q;
  assign O_PC         = pc_q;
  assign O_Opcode     = opcode_q;
  assign O_DestRegIdx = dest_q;
  assign O_Src1Value  = src1_q;
  assign O_Src2Value  = src2_q;
  assign O_DepStall   = dep_stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, reset corner cases, then random
// instruction streams checked against a register/scoreboard model.
module tb_decode_stage;

  logic        I_CLOCK, I_LOCK;
  logic [15:0] I_PC;
  logic [31:0] I_IR;
  logic        I_FetchStall, I_WriteBackEnable;
  logic [3:0]  I_WriteBackRegIdx;
  logic [15:0] I_WriteBackData;
  logic        I_BranchAddrSelect;
  logic        O_LOCK;
  logic [15:0] O_PC;
  logic [7:0]  O_Opcode;
  logic [3:0]  O_DestRegIdx;
  logic [15:0] O_Src1Value, O_Src2Value;
  logic        O_DepStall, O_DepStallSignal, O_BranchStallSignal;

  decode_stage dut (
    .I_CLOCK             (I_CLOCK),
    .I_LOCK              (I_LOCK),
    .I_PC                (I_PC),
    .I_IR                (I_IR),
    .I_FetchStall        (I_FetchStall),
    .I_WriteBackEnable   (I_WriteBackEnable),
    .I_WriteBackRegIdx   (I_WriteBackRegIdx),
    .I_WriteBackData     (I_WriteBackData),
    .I_BranchAddrSelect  (I_BranchAddrSelect),
    .O_LOCK              (O_LOCK),
    .O_PC                (O_PC),
    .O_Opcode            (O_Opcode),
    .O_DestRegIdx        (O_DestRegIdx),
    .O_Src1Value         (O_Src1Value),
    .O_Src2Value         (O_Src2Value),
    .O_DepStall          (O_DepStall),
    .O_DepStallSignal    (O_DepStallSignal),
    .O_BranchStallSignal (O_BranchStallSignal)
  );

  initial begin
    I_CLOCK = 1'b1;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  localparam logic [7:0] T_ADD = 8'h00, T_ADDI = 8'h10, T_STW = 8'h21;
  localparam logic [7:0] T_BR = 8'h30, T_JMP = 8'h31;
  localparam int K_RR = 0, K_RI = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JMP = 5, K_HALT = 6, K_NOP = 7;

  typedef struct {
    logic [31:0] ir;
    logic [15:0] pc;
    logic        fs;
    logic        wbe;
    logic [3:0]  wbi;
    logic [15:0] wbd;
    logic        bas;
    logic        dep;
    logic        br;
    logic        iss;
    logic [15:0] s1;
    logic [15:0] s2;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  vec_t tbl[20];
  int   n_tbl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [7:0] op, input logic [3:0] d, s1, s2);
    return {op, d, s1, s2, 12'h000};
  endfunction

  function automatic logic [31:0] ri(input logic [7:0] op, input logic [3:0] d, s1,
                                     input logic [15:0] imm);
    return {op, d, s1, imm};
  endfunction

  function automatic vec_t mkv(input logic [31:0] ir, input logic [15:0] pc,
                               input logic fs, wbe, input logic [3:0] wbi,
                               input logic [15:0] wbd, input logic bas, dep, br, iss,
                               input logic [15:0] s1, s2);
    vec_t v;
    v.ir = ir; v.pc = pc; v.fs = fs; v.wbe = wbe; v.wbi = wbi; v.wbd = wbd; v.bas = bas;
    v.dep = dep; v.br = br; v.iss = iss; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic add(input vec_t v);
    tbl[n_tbl] = v;
    n_tbl++;
  endtask

  task automatic drive(input vec_t v);
    I_IR = v.ir; I_PC = v.pc; I_FetchStall = v.fs;
    I_WriteBackEnable = v.wbe; I_WriteBackRegIdx = v.wbi; I_WriteBackData = v.wbd;
    I_BranchAddrSelect = v.bas;
  endtask

  // Inputs change just after a falling edge; stall outputs are sampled mid-cycle,
  // latch outputs 1 time unit after the next falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] ir_v;
    ir_v = v.ir;
    drive(v);
    #2;
    chk({tag, ".dep_sig"}, 32'(O_DepStallSignal), 32'(v.dep));
    chk({tag, ".br_sig"}, 32'(O_BranchStallSignal), 32'(v.br));
    @(negedge I_CLOCK);
    #1;
    chk({tag, ".dep_stall"}, 32'(O_DepStall), 32'(!v.iss));
    chk({tag, ".opcode"}, 32'(O_Opcode), v.iss ? 32'(ir_v[31:24]) : 32'h0000_00FF);
    if (v.iss) begin
      chk({tag, ".dest"}, 32'(O_DestRegIdx), 32'(ir_v[23:20]));
      chk({tag, ".pc"}, 32'(O_PC), 32'(v.pc));
      chk({tag, ".src1"}, 32'(O_Src1Value), 32'(v.s1));
      chk({tag, ".src2"}, 32'(O_Src2Value), 32'(v.s2));
    end
  endtask

  function automatic int cls_of(input logic [7:0] op);
    case (op)
      8'h00, 8'h01, 8'h02, 8'h03: return K_RR;
      8'h10, 8'h11:               return K_RI;
      8'h20:                      return K_LD;
      8'h21:                      return K_ST;
      8'h30:                      return K_BR;
      8'h31:                      return K_JMP;
      8'hF0:                      return K_HALT;
      default:                    return K_NOP;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        v;
    logic [15:0] m_gpr[16];
    logic        m_busy[16];
    logic        m_pend;
    logic [7:0]  ops[13];

    // Reset held while an ALU_RR sits in FE/DE.
    I_LOCK = 1'b0;
    drive(mkv(32'h0012_3000, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0,
              1'b0, 1'b0, 1'b0, 16'h0, 16'h0));
    #2;
    chk("rst.dep_sig", 32'(O_DepStallSignal), 32'd0);
    chk("rst.br_sig", 32'(O_BranchStallSignal), 32'd0);
    repeat (2) @(negedge I_CLOCK);
    #1;
    chk("rst.dep_stall", 32'(O_DepStall), 32'd1);
    chk("rst.opcode", 32'(O_Opcode), 32'h0000_00FF);
    chk("rst.lock", 32'(O_LOCK), 32'd0);
    chk("rst.pc", 32'(O_PC), 32'd0);
    chk("rst.dest", 32'(O_DestRegIdx), 32'd0);
    chk("rst.src1", 32'(O_Src1Value), 32'd0);
    chk("rst.src2", 32'(O_Src2Value), 32'd0);
    I_LOCK = 1'b1;

    // Every GPR reads zero after reset.
    for (int i = 0; i < 8; i++) begin
      run_vec(mkv(rr(T_STW, 4'h0, 4'(2 * i), 4'(2 * i + 1)), 16'h0080, 1'b0, 1'b0, 4'h0,
                  16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0), $sformatf("zero%0d", i));
    end
    chk("lock_after_release", 32'(O_LOCK), 32'd1);

    //     ir                              pc        fs    wbe   wbi   wbd        bas   dep   br    iss   s1         s2
    add(mkv(rr(T_ADD, 1, 2, 3),            16'h0100, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 4, 1, 5),            16'h0104, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 4, 1, 5),            16'h0104, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 4, 1, 5),            16'h0104, 1'b0, 1'b1, 4'h1, 16'h00AB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, 16'h0000));
    add(mkv(ri(T_ADDI, 6, 1, 16'hFFF0),    16'h0108, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, 16'hFFF0));
    add(mkv(ri(T_ADDI, 7, 0, 16'h0005),    16'h010C, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_STW, 0, 7, 0),            16'h0110, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000));
    add(mkv(rr(T_BR, 0, 0, 0),             16'h0010, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 8, 4, 0),            16'h0014, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 8, 4, 0),            16'h0014, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 8, 0, 0),            16'h0014, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000));
    add(mkv(rr(T_JMP, 0, 4, 0),            16'h0200, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 0, 0, 0),            16'h0204, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_BR, 0, 6, 0),             16'h0300, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_BR, 0, 6, 0),             16'h0300, 1'b0, 1'b1, 4'h6, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000));
    add(mkv(32'hFF00_0000,                 16'h0304, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_ADD, 2, 0, 0),            16'h0400, 1'b0, 1'b1, 4'h2, 16'h00CD, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000));
    add(mkv(rr(T_STW, 0, 2, 0),            16'h0404, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000));
    add(mkv(rr(T_STW, 0, 2, 0),            16'h0404, 1'b0, 1'b1, 4'h2, 16'h00CD, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00CD, 16'h0000));
    add(mkv(rr(T_STW, 0, 0, 2),            16'h0408, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h00CD));
    for (int i = 0; i < n_tbl; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset while a branch is pending; r4 and r8 are still busy from the table.
    run_vec(mkv(rr(T_BR, 0, 0, 0), 16'h0500, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0,
                1'b0, 1'b1, 1'b1, 16'h0, 16'h0), "midrst.br");
    drive(mkv(32'h0, 16'h0504, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0));
    #2;
    chk("midrst.pending_before", 32'(O_BranchStallSignal), 32'd1);
    I_LOCK = 1'b0;
    #1;
    chk("midrst.br_sig_drop", 32'(O_BranchStallSignal), 32'd0);
    chk("midrst.dep_stall", 32'(O_DepStall), 32'd1);
    @(negedge I_CLOCK);
    #1;
    chk("midrst.lock", 32'(O_LOCK), 32'd0);
    I_LOCK = 1'b1;
    run_vec(mkv(rr(T_STW, 0, 4, 8), 16'h0600, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0,
                1'b0, 1'b0, 1'b1, 16'h0, 16'h0), "midrst.no_stale");

    // Random streams against the model; registers 0..7 only, to provoke hazards.
    ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'h21,
            8'h30, 8'h31, 8'hF0, 8'hFF, 8'h77};
    for (int i = 0; i < 16; i++) begin
      m_gpr[i]  = 16'h0;
      m_busy[i] = 1'b0;
    end
    m_pend = 1'b0;
    for (int n = 0; n < 500; n++) begin
      logic [7:0]  op;
      logic [3:0]  d, s1, s2;
      logic [11:0] lo;
      logic        rd1, rd2, wr, isbr, valid, hz, b1, b2;
      int          c;
      op = ops[$urandom_range(0, 12)];
      d  = 4'($urandom_range(0, 7));
      s1 = 4'($urandom_range(0, 7));
      s2 = 4'($urandom_range(0, 7));
      lo = 12'($urandom);
      v.ir  = {op, d, s1, s2, lo};
      v.pc  = 16'($urandom);
      v.fs  = ($urandom_range(0, 9) == 0);
      v.wbe = ($urandom_range(0, 9) < 4);
      v.wbi = 4'($urandom_range(0, 7));
      v.wbd = 16'($urandom);
      v.bas = m_pend && ($urandom_range(0, 3) == 0);
      c     = cls_of(op);
      rd1   = !(c == K_NOP || c == K_HALT || c == K_JMP);
      rd2   = (c == K_RR || c == K_ST);
      wr    = (c == K_RR || c == K_RI || c == K_LD);
      isbr  = (c == K_BR || c == K_JMP);
      valid = !v.fs && (c != K_NOP);
      b1    = v.wbe && (v.wbi == s1);
      b2    = v.wbe && (v.wbi == s2);
      hz    = valid && ((rd1 && m_busy[s1] && !b1) || (rd2 && m_busy[s2] && !b2));
      v.dep = hz && !m_pend;
      v.br  = m_pend || (valid && isbr && !hz);
      v.iss = valid && !hz && !m_pend;
      v.s1  = b1 ? v.wbd : m_gpr[s1];
      v.s2  = rd2 ? (b2 ? v.wbd : m_gpr[s2]) : {s2, lo};
      run_vec(v, $sformatf("rnd%0d", n));
      if (v.wbe) begin
        m_gpr[v.wbi]  = v.wbd;
        m_busy[v.wbi] = 1'b0;
      end
      if (v.iss && wr) m_busy[d] = 1'b1;
      if (v.iss && isbr) m_pend = 1'b1;
      else if (v.bas) m_pend = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
